enemy_wave_manager: RTL and testbench

//  Parametrised enemy-slot controller for the space-invader datapath. Holds N

---
 rtl/enemy_wave_manager.sv | 203 ++++++++++++++++++++
 tb/tb_enemy_wave_manager.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_wave_manager.sv
// Enemy slot controller for the space-invader datapath.
// Keeps N enemy slots and spawns new enemies into free slots using a free-running LFSR.
// Moves live enemies down on a tick, applies bullet hits and accumulates a weighted score.
// Latches game over when a live enemy reaches the ship line.
// The renderer reads slot state through alive_mask and a registered read port.
module enemy_wave_manager #(
  parameter int          N_ENEMIES = 8,
  parameter int          HEALTH_W  = 3,
  parameter int          X_W       = 10,
  parameter int          Y_W       = 9,
  parameter int          X_MAX     = 600,
  parameter int          Y_BREACH  = 440,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         IDX_W     = $clog2(N_ENEMIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spawn_req_i,
  output logic                 spawn_ack_o,
  output logic                 full_o,
  input  logic                 move_tick_i,
  input  logic                 hit_valid_i,
  input  logic [IDX_W-1:0]     hit_idx_i,
  input  logic [HEALTH_W-1:0]  hit_dmg_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic                 rd_alive_o,
  output logic [1:0]           rd_type_o,
  output logic [HEALTH_W-1:0]  rd_health_o,
  output logic [X_W-1:0]       rd_x_o,
  output logic [Y_W-1:0]       rd_y_o,
  output logic [N_ENEMIES-1:0] alive_mask_o,
  output logic [15:0]          score_o,
  output logic                 game_over_o
);

  // Folds the 10-bit LFSR field into 0..X_MAX-1.
  // There is one conditional subtract; a value still out of range clamps to 0.
  function automatic logic [X_W-1:0] spawn_x(input logic [9:0] raw);
    int r;
    r = int'(raw);
    if (r >= X_MAX) r = r - X_MAX;
    if (r >= X_MAX) r = 0;
    return X_W'(r);
  endfunction

  // Advance y by type+1, saturating at the top of the y range.
  function automatic logic [Y_W-1:0] y_step(input logic [Y_W-1:0] y, input logic [1:0] t);
    logic [Y_W:0] s;
    s = {1'b0, y} + (Y_W+1)'(t) + (Y_W+1)'(1);
    return s[Y_W] ? '1 : s[Y_W-1:0];
  endfunction

  // Add a kill worth type+1 points, saturating at 16'hFFFF.
  function automatic logic [15:0] score_add(input logic [15:0] s, input logic [1:0] t);
    logic [16:0] sum;
    sum = {1'b0, s} + 17'(t) + 17'd1;
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [N_ENEMIES-1:0] alive_q, alive_d;
  logic [1:0]           type_q   [N_ENEMIES];
  logic [1:0]           type_d   [N_ENEMIES];
  logic [HEALTH_W-1:0]  health_q [N_ENEMIES];
  logic [HEALTH_W-1:0]  health_d [N_ENEMIES];
  logic [X_W-1:0]       x_q      [N_ENEMIES];
  logic [X_W-1:0]       x_d      [N_ENEMIES];
  logic [Y_W-1:0]       y_q      [N_ENEMIES];
  logic [Y_W-1:0]       y_d      [N_ENEMIES];

  logic [15:0]          lfsr_q, lfsr_d;
  logic [15:0]          score_q, score_d;
  logic                 game_over_q, game_over_d;
  logic                 full_q, spawn_ack_q;
  logic                 free_found, spawn_go, breach;
  logic [IDX_W-1:0]     free_idx;
  logic [N_ENEMIES-1:0] hit_sel;

  logic                 rd_alive_q;
  logic [1:0]           rd_type_q;
  logic [HEALTH_W-1:0]  rd_health_q;
  logic [X_W-1:0]       rd_x_q;
  logic [Y_W-1:0]       rd_y_q;

  // Fibonacci LFSR step, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Breach detect on registered slot state; the flag is sticky once set.
  always_comb begin
    breach = 1'b0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      if (alive_q[i] && (int'(y_q[i]) >= Y_BREACH)) breach = 1'b1;
    end
    game_over_d = game_over_q | breach;
  end

  // Slot next state: the spawn target is found on start-of-cycle occupancy.
  // Hits apply first, then moves on survivors, then the spawn writes a slot that was already dead.
  always_comb begin
    alive_d    = alive_q;
    type_d     = type_q;
    health_d   = health_q;
    x_d        = x_q;
    y_d        = y_q;
    score_d    = score_q;
    hit_sel    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_ENEMIES - 1; i >= 0; i--) begin
      if (!alive_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    spawn_go = spawn_req_i && !full_q && !game_over_q && free_found;
    if (!game_over_q) begin
      for (int i = 0; i < N_ENEMIES; i++) begin
        hit_sel[i] = hit_valid_i && alive_q[i] && (hit_idx_i == IDX_W'(i));
        if (hit_sel[i] && (hit_dmg_i >= health_q[i])) begin
          alive_d[i]  = 1'b0;
          health_d[i] = '0;
          score_d     = score_add(score_q, type_q[i]);
        end else begin
          if (hit_sel[i]) health_d[i] = health_q[i] - hit_dmg_i;
          if (move_tick_i && alive_q[i]) y_d[i] = y_step(y_q[i], type_q[i]);
        end
      end
      if (spawn_go) begin
        alive_d[free_idx]  = 1'b1;
        type_d[free_idx]   = lfsr_q[1:0];
        health_d[free_idx] = HEALTH_W'(lfsr_q[1:0]) + HEALTH_W'(1);
        x_d[free_idx]      = spawn_x(lfsr_q[15:6]);
        y_d[free_idx]      = '0;
      end
    end
  end

  // Control registers: LFSR, score, game over, full and spawn acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= LFSR_SEED;
      score_q     <= '0;
      game_over_q <= 1'b0;
      full_q      <= 1'b0;
      spawn_ack_q <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      score_q     <= score_d;
      game_over_q <= game_over_d;
      full_q      <= &alive_d;
      spawn_ack_q <= spawn_go;
    end
  end

  // Slot storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      alive_q <= '0;
      for (int i = 0; i < N_ENEMIES; i++) begin
        type_q[i]   <= '0;
        health_q[i] <= '0;
        x_q[i]      <= '0;
        y_q[i]      <= '0;
      end
    end else begin
      alive_q  <= alive_d;
      type_q   <= type_d;
      health_q <= health_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  // Registered renderer read port, one cycle behind rd_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_alive_q  <= 1'b0;
      rd_type_q   <= '0;
      rd_health_q <= '0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
    end else begin
      rd_alive_q  <= alive_q[rd_idx_i];
      rd_type_q   <= type_q[rd_idx_i];
      rd_health_q <= health_q[rd_idx_i];
      rd_x_q      <= x_q[rd_idx_i];
      rd_y_q      <= y_q[rd_idx_i];
    end
  end

  assign spawn_ack_o  = spawn_ack_q;
  assign full_o       = full_q;
  assign alive_mask_o = alive_q;
  assign score_o      = score_q;
  assign game_over_o  = game_over_q;
  assign rd_alive_o   = rd_alive_q;
  assign rd_type_o    = rd_type_q;
  assign rd_health_o  = rd_health_q;
  assign rd_x_o       = rd_x_q;
  assign rd_y_o       = rd_y_q;

endmodule

// File: tb/tb_enemy_wave_manager.sv
// Testbench for enemy_wave_manager.
// A reference model of the slot rules produces one expected output record per cycle.
// A monitor compares each record with the DUT outputs after the following clock edge.
module tb_enemy_wave_manager;

  localparam int N    = 8;
  localparam int XMAX = 600;
  localparam int YBR  = 440;
  localparam int YTOP = 511;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spawn_req = 1'b0, move_tick = 1'b0, hit_valid = 1'b0;
  logic [2:0] hit_idx = '0, hit_dmg = '0, rd_idx = '0;
  logic       spawn_ack, full, rd_alive, game_over;
  logic [1:0] rd_type;
  logic [2:0] rd_health;
  logic [9:0] rd_x;
  logic [8:0] rd_y;
  logic [7:0] alive_mask;
  logic [15:0] score;

  enemy_wave_manager dut (
    .clk(clk), .rst(rst),
    .spawn_req_i(spawn_req), .spawn_ack_o(spawn_ack), .full_o(full),
    .move_tick_i(move_tick), .hit_valid_i(hit_valid), .hit_idx_i(hit_idx),
    .hit_dmg_i(hit_dmg), .rd_idx_i(rd_idx),
    .rd_alive_o(rd_alive), .rd_type_o(rd_type), .rd_health_o(rd_health),
    .rd_x_o(rd_x), .rd_y_o(rd_y), .alive_mask_o(alive_mask),
    .score_o(score), .game_over_o(game_over)
  );

  always #5 clk = ~clk;

  typedef struct { bit alive; int typ; int hp; int x; int y; } slot_t;
  typedef struct {
    bit ack; bit full; int mask; int score; bit go;
    bit ra; int rt; int rh; int rx; int ry;
  } exp_t;

  slot_t     m_slot [N];
  bit [15:0] m_lfsr;
  int        m_score;
  bit        m_go;
  exp_t      sb_q [$];
  int        n_checks = 0;
  int        n_err    = 0;
  bit        stim_done = 1'b0;

  function automatic bit [15:0] lfsr_next(bit [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference model: one call per clock cycle with that cycle's inputs.
  task automatic model_step(bit r, bit sp, bit mv, bit hv, int hidx, int hdmg, int rdi);
    exp_t e;
    int   free;
    bit   breach;
    e = '{default: 0};
    if (r) begin
      for (int i = 0; i < N; i++) m_slot[i] = '{default: 0};
      m_lfsr  = 16'hACE1;
      m_score = 0;
      m_go    = 1'b0;
    end else begin
      e.ra = m_slot[rdi].alive;
      e.rt = m_slot[rdi].typ;
      e.rh = m_slot[rdi].hp;
      e.rx = m_slot[rdi].x;
      e.ry = m_slot[rdi].y;
      breach = 1'b0;
      free   = -1;
      for (int i = 0; i < N; i++) begin
        if (m_slot[i].alive && m_slot[i].y >= YBR) breach = 1'b1;
        if (!m_slot[i].alive && free < 0) free = i;
      end
      if (!m_go) begin
        if (hv && m_slot[hidx].alive) begin
          if (hdmg >= m_slot[hidx].hp) begin
            m_slot[hidx].alive = 1'b0;
            m_slot[hidx].hp    = 0;
            m_score = m_score + m_slot[hidx].typ + 1;
            if (m_score > 65535) m_score = 65535;
          end else begin
            m_slot[hidx].hp = m_slot[hidx].hp - hdmg;
          end
        end
        if (mv) begin
          for (int i = 0; i < N; i++) begin
            if (m_slot[i].alive) begin
              m_slot[i].y = m_slot[i].y + m_slot[i].typ + 1;
              if (m_slot[i].y > YTOP) m_slot[i].y = YTOP;
            end
          end
        end
        if (sp && free >= 0) begin
          m_slot[free].alive = 1'b1;
          m_slot[free].typ   = int'(m_lfsr[1:0]);
          m_slot[free].hp    = m_slot[free].typ + 1;
          m_slot[free].x     = int'(m_lfsr[15:6]) % XMAX;
          m_slot[free].y     = 0;
          e.ack = 1'b1;
        end
      end
      m_go   = m_go || breach;
      m_lfsr = lfsr_next(m_lfsr);
    end
    e.mask = 0;
    for (int i = 0; i < N; i++) if (m_slot[i].alive) e.mask = e.mask | (1 << i);
    e.full  = (e.mask == 8'hFF);
    e.score = m_score;
    e.go    = m_go;
    sb_q.push_back(e);
  endtask

  task automatic drive(bit r, bit sp, bit mv, bit hv, int hidx, int hdmg, int rdi);
    @(negedge clk);
    rst       = r;
    spawn_req = sp;
    move_tick = mv;
    hit_valid = hv;
    hit_idx   = 3'(hidx);
    hit_dmg   = 3'(hdmg);
    rd_idx    = 3'(rdi);
    model_step(r, sp, mv, hv, hidx, hdmg, rdi);
  endtask

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh output set one step after the edge.
  initial begin
    exp_t e;
    int   idle;
    idle = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("spawn_ack",  int'(spawn_ack),  int'(e.ack));
        check("full",       int'(full),       int'(e.full));
        check("alive_mask", int'(alive_mask), e.mask);
        check("score",      int'(score),      e.score);
        check("game_over",  int'(game_over),  int'(e.go));
        check("rd_alive",   int'(rd_alive),   int'(e.ra));
        check("rd_type",    int'(rd_type),    e.rt);
        check("rd_health",  int'(rd_health),  e.rh);
        check("rd_x",       int'(rd_x),       e.rx);
        check("rd_y",       int'(rd_y),       e.ry);
      end
      if (stim_done) begin
        idle++;
        if (sb_q.size() == 0 || idle > 10) begin
          check("drain", sb_q.size(), 0);
          $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
          $finish;
        end
      end
    end
  end

  // Hard time bound in case the clock or the monitor stalls.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed scenarios followed by a randomized run.
  initial begin
    // reset, then one spawn and read slot 0 back
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    // fill all slots; the ninth request is refused
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 0, 0, i);
    drive(0, 0, 0, 0, 0, 0, 7);
    // whittle slot 2 down one point at a time until it dies
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 2, 1, 2);
    drive(0, 0, 0, 0, 0, 0, 2);
    drive(0, 0, 0, 1, 2, 3, 2);
    // four live slots: hit a dead slot, then kill slot 0 while spawning
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0, i);
    drive(0, 0, 0, 1, 5, 3, 5);
    drive(0, 1, 0, 1, 0, 7, 4);
    drive(0, 1, 0, 0, 0, 0, 4);
    drive(0, 0, 0, 0, 0, 0, 0);
    // hit and move on the same slot in one cycle
    drive(0, 0, 1, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    // single enemy marched to the breach line, then everything frozen
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 460; i++) drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 7, 0);
    drive(0, 1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 599) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 0),
            int'($urandom_range(0, 7)),
            int'($urandom_range(0, 4)),
            int'($urandom_range(0, 7)));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    stim_done = 1'b1;
  end

endmodule
